// File: rtl/clock_enable_gen.sv
// Clock-enable generator: derives the 14 MHz, 7 MHz pixel and turbo-selectable CPU enable
// strobes from the 56 MHz system clock, and a stretched, synchronously released system reset.
module clock_enable_gen #(
  parameter int unsigned RESET_CYCLES = 1024,
  parameter int unsigned RCW          = 11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       boot,
  input  logic [1:0] turbo,
  input  logic       pause,
  output logic       rst_n,
  output logic       ce14,
  output logic       ce7p,
  output logic       ce7n,
  output logic       cpup,
  output logic       cpun,
  output logic [1:0] turbo_act
);

  localparam logic [RCW-1:0] RcMax = RCW'(RESET_CYCLES);

  logic [1:0]     sync_q;
  logic           sreset_n;
  logic [3:0]     cc_q;
  logic           pause_act_q;
  logic [RCW-1:0] rc_q;
  logic           cpup_d;
  logic           cpun_d;

  // Two-flop synchroniser for the release edge of the PLL-locked reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign sreset_n = sync_q[1];

  // Free-running phase counter; the only timebase for every strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cc_q <= 4'd0;
    end else if (!sreset_n) begin
      cc_q <= 4'd0;
    end else begin
      cc_q <= cc_q + 4'd1;
    end
  end

  // Speed and pause are only sampled at the end of a 16-cycle frame so that a CPU cycle
  // in flight is never cut short or merged with the next one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      turbo_act   <= 2'd0;
      pause_act_q <= 1'b0;
    end else if (!sreset_n) begin
      turbo_act   <= 2'd0;
      pause_act_q <= 1'b0;
    end else if (cc_q == 4'hf) begin
      turbo_act   <= turbo;
      pause_act_q <= pause;
    end
  end

  // CPU strobe decode: rising phase ends each CPU period, falling phase sits mid-period.
  always_comb begin
    cpup_d = 1'b0;
    cpun_d = 1'b0;
    unique case (turbo_act)
      2'd0: begin
        cpup_d = (cc_q == 4'hf);
        cpun_d = (cc_q == 4'h7);
      end
      2'd1: begin
        cpup_d = (cc_q[2:0] == 3'd7);
        cpun_d = (cc_q[2:0] == 3'd3);
      end
      2'd2: begin
        cpup_d = (cc_q[1:0] == 2'd3);
        cpun_d = (cc_q[1:0] == 2'd1);
      end
      default: begin
        cpup_d = cc_q[0];
        cpun_d = ~cc_q[0];
      end
    endcase
    if (pause_act_q) begin
      cpup_d = 1'b0;
      cpun_d = 1'b0;
    end
  end

  // Registered strobes; they keep running while rst_n is low so held logic still sees clocks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ce14 <= 1'b0;
      ce7p <= 1'b0;
      ce7n <= 1'b0;
      cpup <= 1'b0;
      cpun <= 1'b0;
    end else if (!sreset_n) begin
      ce14 <= 1'b0;
      ce7p <= 1'b0;
      ce7n <= 1'b0;
      cpup <= 1'b0;
      cpun <= 1'b0;
    end else begin
      ce14 <= (cc_q[1:0] == 2'd3);
      ce7p <= (cc_q[2:0] == 3'd3);
      ce7n <= (cc_q[2:0] == 3'd7);
      cpup <= cpup_d;
      cpun <= cpun_d;
    end
  end

  // Reset stretcher; boot restarts the hold and wins over counting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rc_q  <= '0;
      rst_n <= 1'b0;
    end else if (!sreset_n) begin
      rc_q  <= '0;
      rst_n <= 1'b0;
    end else if (boot) begin
      rc_q  <= '0;
      rst_n <= 1'b0;
    end else begin
      if (rc_q < RcMax) begin
        rc_q <= rc_q + RCW'(1);
      end
      rst_n <= (rc_q == RcMax);
    end
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Self-checking bench for clock_enable_gen with a frame-arithmetic reference model.
module tb_clock_enable_gen;

  localparam int R = 20;
  localparam int W = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       boot  = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] turbo = 2'd0;
  logic       rst_n, ce14, ce7p, ce7n, cpup, cpun;
  logic [1:0] turbo_act;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  clock_enable_gen #(
    .RESET_CYCLES(R),
    .RCW         (W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .boot     (boot),
    .turbo    (turbo),
    .pause    (pause),
    .rst_n    (rst_n),
    .ce14     (ce14),
    .ce7p     (ce7p),
    .ce7n     (ce7n),
    .cpup     (cpup),
    .cpun     (cpun),
    .turbo_act(turbo_act)
  );

  // Bit order: rst_n ce14 ce7p ce7n cpup cpun turbo_act[1:0]
  logic [7:0] obs_vec;
  assign obs_vec = {rst_n, ce14, ce7p, ce7n, cpup, cpun, turbo_act};

  // Reference model. k_q counts edges since reset release; the phase after edge k is
  // (k-2) mod 16 once the 2-edge synchroniser has released. The CPU period is 16>>mode
  // cycles, rising strobe at the last phase of a period, falling strobe at mid-period.
  // rst_n is high once R+1 edges have elapsed since the hold started (sync release or
  // the most recent boot edge) and boot is not asserted.
  int         k_q, start_q, start_n, c, per;
  logic [1:0] mt_q, mt_n;
  logic       mp_q, mp_n;
  logic [7:0] exp_vec, ev_n;

  always_comb begin
    c       = (k_q >= 2) ? (k_q - 2) % 16 : 0;
    per     = 16 >> mt_q;
    start_n = (k_q >= 2 && boot) ? k_q + 1 : start_q;
    mt_n    = mt_q;
    mp_n    = mp_q;
    ev_n    = '0;
    if (k_q >= 2) begin
      ev_n[7] = !boot && (k_q + 1 >= start_n + R + 1);
      ev_n[6] = (c % 4 == 3);
      ev_n[5] = (c % 8 == 3);
      ev_n[4] = (c % 8 == 7);
      ev_n[3] = !mp_q && (c % per == per - 1);
      ev_n[2] = !mp_q && (c % per == per / 2 - 1);
      if (c == 15) begin
        mt_n = turbo;
        mp_n = pause;
      end
      ev_n[1:0] = mt_n;
    end
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      k_q     <= 0;
      start_q <= 2;
      mt_q    <= 2'd0;
      mp_q    <= 1'b0;
      exp_vec <= '0;
    end else begin
      k_q     <= k_q + 1;
      start_q <= start_n;
      mt_q    <= mt_n;
      mp_q    <= mp_n;
      exp_vec <= ev_n;
    end
  end

  // Wait (bounded) until the model phase equals t, sampled on a falling edge.
  task automatic wait_cc(input int t);
    for (int i = 0; i < 32 && c != t; i++) @(negedge clock);
  endtask

  task automatic test_reset();
    int first_ce14, first_rst;
    reset = 1'b0; boot = 1'b0; pause = 1'b0; turbo = 2'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_total++;
      if (obs_vec !== 8'h00) $display("FAIL reset_held cyc=%0d dut=%b want=00000000", i, obs_vec);
      else n_pass++;
    end
    reset = 1'b1;
    first_ce14 = -1;
    first_rst  = -1;
    for (int i = 1; i <= R + 10; i++) begin
      @(negedge clock);
      n_total++;
      if (obs_vec !== exp_vec) $display("FAIL powerup cyc=%0d dut=%b model=%b", i, obs_vec, exp_vec);
      else n_pass++;
      if (ce14 && first_ce14 < 0) first_ce14 = i;
      if (rst_n && first_rst < 0) first_rst = i;
    end
    // 2 sync edges, phases 0..3, then the strobe register.
    n_total++;
    if (first_ce14 != 6) $display("FAIL first_ce14 edge=%0d want=6", first_ce14);
    else n_pass++;
    n_total++;
    if (first_rst != R + 3) $display("FAIL rst_release edge=%0d want=%0d", first_rst, R + 3);
    else n_pass++;
  endtask

  task automatic test_turbo0();
    int np, nn, n7p, n7n, n14, last_p;
    bit spacing_ok;
    turbo = 2'd0;
    np = 0; nn = 0; n7p = 0; n7n = 0; n14 = 0; last_p = -1; spacing_ok = 1'b1;
    for (int i = 0; i < 160; i++) begin
      @(negedge clock);
      n_total++;
      if (obs_vec !== exp_vec) $display("FAIL turbo0 cyc=%0d dut=%b model=%b", i, obs_vec, exp_vec);
      else n_pass++;
      if (cpup) begin
        if (last_p >= 0 && i - last_p != 16) spacing_ok = 1'b0;
        last_p = i;
        np++;
      end
      if (cpun) begin
        if (last_p >= 0 && i - last_p != 8) spacing_ok = 1'b0;
        nn++;
      end
      n7p += int'(ce7p);
      n7n += int'(ce7n);
      n14 += int'(ce14);
    end
    n_total++;
    if (np != 10 || nn != 10) $display("FAIL turbo0_cpu cpup=%0d cpun=%0d want=10/10", np, nn);
    else n_pass++;
    n_total++;
    if (n7p != 20 || n7n != 20 || n14 != 40)
      $display("FAIL turbo0_ce ce7p=%0d ce7n=%0d ce14=%0d want=20/20/40", n7p, n7n, n14);
    else n_pass++;
    n_total++;
    if (!spacing_ok) $display("FAIL turbo0_spacing got=irregular want=16 period, 8 offset");
    else n_pass++;
  endtask

  task automatic test_turbo_switch();
    logic [1:0] prev_ta;
    bit seen, ta_ok;
    int win, np, nn;
    wait_cc(5);
    turbo = 2'd3;
    prev_ta = turbo_act;
    seen = 1'b0; ta_ok = 1'b0; win = 0; np = 0; nn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      n_total++;
      if (obs_vec !== exp_vec) $display("FAIL turbo_switch cyc=%0d dut=%b model=%b", i, obs_vec, exp_vec);
      else n_pass++;
      if (!seen && c == 0) begin
        seen  = 1'b1;
        ta_ok = (turbo_act === 2'd3) && (prev_ta === 2'd0);
      end else if (seen && win < 16) begin
        win++;
        np += int'(cpup);
        nn += int'(cpun);
      end
      prev_ta = turbo_act;
    end
    n_total++;
    if (!ta_ok) $display("FAIL turbo_act_step seen=%0d ok=%0d want=1/1", seen, ta_ok);
    else n_pass++;
    n_total++;
    if (np != 8 || nn != 8) $display("FAIL turbo3_frame cpup=%0d cpun=%0d want=8/8", np, nn);
    else n_pass++;
  endtask

  task automatic test_pause();
    int run, maxrun, n14, np, nn;
    wait_cc(10);
    pause = 1'b1;
    run = 0; maxrun = 0; n14 = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clock);
      n_total++;
      if (obs_vec !== exp_vec) $display("FAIL pause cyc=%0d dut=%b model=%b", i, obs_vec, exp_vec);
      else n_pass++;
      if (c == 1) pause = 1'b0;
      if (cpup || cpun) begin
        if (run > maxrun) maxrun = run;
        run = 0;
      end else begin
        run++;
      end
      n14 += int'(ce14);
    end
    if (run > maxrun) maxrun = run;
    n_total++;
    if (maxrun != 16) $display("FAIL pause_gap got=%0d want=16", maxrun);
    else n_pass++;
    n_total++;
    if (n14 != 12) $display("FAIL pause_ce14 got=%0d want=12", n14);
    else n_pass++;
    // Short pulse away from the frame end must be ignored.
    wait_cc(5);
    pause = 1'b1;
    @(negedge clock);
    pause = 1'b0;
    np = 0; nn = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      n_total++;
      if (obs_vec !== exp_vec) $display("FAIL pause_pulse cyc=%0d dut=%b model=%b", i, obs_vec, exp_vec);
      else n_pass++;
      np += int'(cpup);
      nn += int'(cpun);
    end
    n_total++;
    if (np != 16 || nn != 16) $display("FAIL pause_pulse_cpu cpup=%0d cpun=%0d want=16/16", np, nn);
    else n_pass++;
  endtask

  task automatic test_boot();
    int first_low, first_high, n14;
    wait_cc(3);
    boot = 1'b1;
    first_low = -1; first_high = -1; n14 = 0;
    for (int i = 1; i <= R + 10; i++) begin
      @(negedge clock);
      n_total++;
      if (obs_vec !== exp_vec) $display("FAIL boot cyc=%0d dut=%b model=%b", i, obs_vec, exp_vec);
      else n_pass++;
      if (i == 3) boot = 1'b0;
      if (!rst_n && first_low < 0) first_low = i;
      if (rst_n && first_low >= 0 && first_high < 0) first_high = i;
      if (!rst_n) n14 += int'(ce14);
    end
    n_total++;
    if (first_low != 1) $display("FAIL boot_assert edge=%0d want=1", first_low);
    else n_pass++;
    n_total++;
    if (first_high != R + 4) $display("FAIL boot_release edge=%0d want=%0d", first_high, R + 4);
    else n_pass++;
    n_total++;
    if (n14 == 0) $display("FAIL boot_strobes ce14_during_reset=%0d want=nonzero", n14);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int first_ce14, first_rst;
    wait_cc(9);
    #2 reset = 1'b0;
    #1;
    n_total++;
    if (obs_vec !== 8'h00) $display("FAIL async_clear dut=%b want=00000000", obs_vec);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_total++;
      if (obs_vec !== 8'h00) $display("FAIL async_held cyc=%0d dut=%b want=00000000", i, obs_vec);
      else n_pass++;
    end
    reset = 1'b1;
    first_ce14 = -1;
    first_rst  = -1;
    for (int i = 1; i <= R + 10; i++) begin
      @(negedge clock);
      n_total++;
      if (obs_vec !== exp_vec) $display("FAIL async_restart cyc=%0d dut=%b model=%b", i, obs_vec, exp_vec);
      else n_pass++;
      if (ce14 && first_ce14 < 0) first_ce14 = i;
      if (rst_n && first_rst < 0) first_rst = i;
    end
    n_total++;
    if (first_ce14 != 6) $display("FAIL async_ce14 edge=%0d want=6", first_ce14);
    else n_pass++;
    n_total++;
    if (first_rst != R + 3) $display("FAIL async_rst edge=%0d want=%0d", first_rst, R + 3);
    else n_pass++;
  endtask

  task automatic test_random();
    int np, nn;
    wait_cc(0);
    np = 0; nn = 0;
    for (int i = 0; i < 512; i++) begin
      turbo = 2'($urandom_range(0, 3));
      pause = ($urandom_range(0, 3) == 0);
      boot  = ($urandom_range(0, 63) == 0);
      @(negedge clock);
      n_total++;
      if (obs_vec !== exp_vec) $display("FAIL random cyc=%0d dut=%b model=%b", i, obs_vec, exp_vec);
      else n_pass++;
      n_total++;
      if (cpup && cpun) $display("FAIL cpu_overlap cyc=%0d cpup=%b cpun=%b want=not both", i, cpup, cpun);
      else n_pass++;
      np += int'(cpup);
      nn += int'(cpun);
      if (c == 0) begin
        n_total++;
        if (np != nn) $display("FAIL frame_balance cyc=%0d cpup=%0d cpun=%0d want=equal", i, np, nn);
        else n_pass++;
        np = 0;
        nn = 0;
      end
    end
    boot  = 1'b0;
    pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_turbo0();
    test_turbo_switch();
    test_pause();
    test_boot();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
